// File: rtl/btb_update_queue.sv
// BTB update queue: buffers taken-branch resolutions from MEM and
// writes them into the BTB through a two-cycle probe/write sequence.
module btb_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [15:0]              upd_pc,
    input  logic [15:0]              upd_target,
    input  logic                     upd_taken,
    output logic                     wb_enable,
    output logic [15:0]              old_pc_addr,
    output logic [15:0]              wb_addr,
    output logic                     way0_write,
    output logic                     way1_write,
    output logic                     way2_write,
    output logic                     way3_write,
    output logic                     lru_load,
    input  logic                     wb_hit,
    input  logic                     wb_comp0_out,
    input  logic                     wb_comp1_out,
    input  logic                     wb_comp2_out,
    input  logic                     wb_comp3_out,
    input  logic [2:0]               lru_out,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PROBE = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    way_q, way_d;
    logic [15:0]   pc_mem_q  [DEPTH];
    logic [15:0]   tgt_mem_q [DEPTH];

    logic push;
    logic pop;
    logic busy;
    logic [1:0] way_sel;

    assign upd_ready = (count_q != CW'(DEPTH));
    // Not-taken updates complete the handshake but never enter the queue.
    assign push      = upd_valid & upd_ready & upd_taken;
    assign pop       = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign q_count   = count_q;

    // Outputs decode straight from state so reset kills strobes at once.
    assign wb_enable   = busy;
    assign old_pc_addr = busy ? pc_mem_q[head_q]  : 16'h0;
    assign wb_addr     = busy ? tgt_mem_q[head_q] : 16'h0;
    assign lru_load    = pop;
    assign way0_write  = pop && (way_q == 2'd0);
    assign way1_write  = pop && (way_q == 2'd1);
    assign way2_write  = pop && (way_q == 2'd2);
    assign way3_write  = pop && (way_q == 2'd3);

    // Hit: lowest matching way wins; miss: pseudo-LRU victim.
    always_comb begin
        way_sel = 2'd0;
        if (wb_hit) begin
            if (wb_comp0_out)      way_sel = 2'd0;
            else if (wb_comp1_out) way_sel = 2'd1;
            else if (wb_comp2_out) way_sel = 2'd2;
            else if (wb_comp3_out) way_sel = 2'd3;
            else                   way_sel = 2'd0;
        end else if (!lru_out[0]) begin
            way_sel = lru_out[1] ? 2'd1 : 2'd0;
        end else begin
            way_sel = lru_out[2] ? 2'd3 : 2'd2;
        end
    end

    // Pointer and occupancy bookkeeping for the circular buffer.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop)  head_d = head_q + PW'(1);
        if (push) tail_d = tail_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next state for the probe/write sequencer.
    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 || push) state_d = S_PROBE;
            end
            S_PROBE: begin
                way_d   = way_sel;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (count_q > CW'(1) || push) state_d = S_PROBE;
                else                          state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            way_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            way_q   <= way_d;
        end
    end

    // Entry storage; only the tail slot is ever written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= 16'h0;
                tgt_mem_q[i] <= 16'h0;
            end
        end else if (push) begin
            pc_mem_q[tail_q]  <= upd_pc;
            tgt_mem_q[tail_q] <= upd_target;
        end
    end

endmodule
